// File: rtl/fsm_lockstep_sequencer.sv
// Lockstep driver for the one-hot and binary sequence-detector FSMs: clears both,
// walks a latched w pattern through them one step at a time and counts output disagreements.
module fsm_lockstep_sequencer #(
   parameter  int PAT_LEN  = 8,
   parameter  int STEP_DIV = 4,
   parameter  int CNT_W    = 4,
   localparam int IDX_W    = $clog2(PAT_LEN)
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   input  logic               start_i,
   input  logic               step_mode_i,
   input  logic               step_btn_i,
   input  logic [PAT_LEN-1:0] pattern_i,
   input  logic               z_a_i,
   input  logic               z_b_i,
   output logic               fsm_w_o,
   output logic               fsm_step_o,
   output logic               fsm_clr_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               mismatch_o,
   output logic [CNT_W-1:0]   mismatch_cnt_o,
   output logic [IDX_W-1:0]   bit_idx_o
);

   localparam int               WAIT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STEP_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PAT_LEN - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_DRIVE,
      S_STEP,
      S_SAMPLE,
      S_DONE
   } state_e;

   state_e             state_q;
   logic               start_prev_q;
   logic               start_arm_q;
   logic               btn_prev_q;
   logic               mode_q;
   logic [PAT_LEN-1:0] shift_q;
   logic [WAIT_W-1:0]  wait_q;

   logic               fsm_w_q;
   logic               fsm_step_q;
   logic               fsm_clr_q;
   logic               busy_q;
   logic               done_q;
   logic               mismatch_q;
   logic [CNT_W-1:0]   mismatch_cnt_q;
   logic [IDX_W-1:0]   bit_idx_q;

   logic               start_rise;
   logic               btn_rise;

   // A start held high through reset release must not launch a run: it has to be seen low first.
   assign start_rise = start_i & ~start_prev_q & start_arm_q;
   assign btn_rise   = step_btn_i & ~btn_prev_q;

   // NOTE: every register here is updated with non-blocking assignments so all of them
   // sample the same pre-edge values, regardless of statement order inside the block.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q        <= S_IDLE;
         start_prev_q   <= 1'b0;
         start_arm_q    <= 1'b0;
         btn_prev_q     <= 1'b0;
         mode_q         <= 1'b0;
         shift_q        <= '0;
         wait_q         <= '0;
         fsm_w_q        <= 1'b0;
         fsm_step_q     <= 1'b0;
         fsm_clr_q      <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         mismatch_q     <= 1'b0;
         mismatch_cnt_q <= '0;
         bit_idx_q      <= '0;
      end else begin
         start_prev_q <= start_i;
         btn_prev_q   <= step_btn_i;
         if (!start_i) start_arm_q <= 1'b1;
         fsm_step_q   <= 1'b0;
         fsm_clr_q    <= 1'b0;

         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_rise) begin
                  state_q        <= S_CLEAR;
                  shift_q        <= pattern_i;
                  mode_q         <= step_mode_i;
                  wait_q         <= '0;
                  bit_idx_q      <= '0;
                  mismatch_q     <= 1'b0;
                  mismatch_cnt_q <= '0;
                  fsm_w_q        <= 1'b0;
                  fsm_clr_q      <= 1'b1;
                  busy_q         <= 1'b1;
                  done_q         <= 1'b0;
               end
            end

            S_CLEAR: begin
               state_q <= S_DRIVE;
               fsm_w_q <= shift_q[0];
            end

            S_DRIVE: begin
               if (mode_q) begin
                  if (btn_rise) begin
                     state_q    <= S_STEP;
                     fsm_step_q <= 1'b1;
                  end
               end else if (wait_q == WAIT_LAST) begin
                  state_q    <= S_STEP;
                  fsm_step_q <= 1'b1;
               end else begin
                  wait_q <= wait_q + WAIT_W'(1);
               end
            end

            S_STEP: begin
               state_q <= S_SAMPLE;
            end

            S_SAMPLE: begin
               if (z_a_i != z_b_i) begin
                  mismatch_q <= 1'b1;
                  if (mismatch_cnt_q != CNT_MAX) mismatch_cnt_q <= mismatch_cnt_q + CNT_W'(1);
               end
               if (bit_idx_q == IDX_LAST) begin
                  state_q <= S_DONE;
                  fsm_w_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q   <= S_DRIVE;
                  bit_idx_q <= bit_idx_q + IDX_W'(1);
                  shift_q   <= shift_q >> 1;
                  fsm_w_q   <= shift_q[1];
                  wait_q    <= '0;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign fsm_w_o        = fsm_w_q;
   assign fsm_step_o     = fsm_step_q;
   assign fsm_clr_o      = fsm_clr_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign mismatch_o     = mismatch_q;
   assign mismatch_cnt_o = mismatch_cnt_q;
   assign bit_idx_o      = bit_idx_q;

endmodule

// File: tb/tb_fsm_lockstep_sequencer.sv
// Scoreboard bench for fsm_lockstep_sequencer: random patterns and disagreement masks,
// expected step values and run results derived from the pattern/mask, popped by a monitor.
module tb_fsm_lockstep_sequencer;

   localparam int PAT_LEN  = 8;
   localparam int STEP_DIV = 4;
   localparam int CNT_W    = 4;
   localparam int CNT2_W   = 2;
   localparam int IDX_W    = 3;
   // Edges from the one that sees start rise until done is high; the start-high cycle
   // itself makes up the remaining one of the 1 + 1 + PAT_LEN*(STEP_DIV+2) cycles.
   localparam int RUN_EDGES = 1 + PAT_LEN * (STEP_DIV + 2);

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic step_mode = 1'b0;
   logic step_btn = 1'b0;
   logic [PAT_LEN-1:0] pattern = '0;
   logic z_a = 1'b0;
   logic z_b = 1'b0;

   logic fsm_w, fsm_step, fsm_clr, busy, done, mismatch;
   logic [CNT_W-1:0] mismatch_cnt;
   logic [IDX_W-1:0] bit_idx;
   logic w2, step2, clr2, busy2, done2, mism2;
   logic [CNT2_W-1:0] cnt2;
   logic [IDX_W-1:0] idx2;

   fsm_lockstep_sequencer #(.PAT_LEN(PAT_LEN), .STEP_DIV(STEP_DIV), .CNT_W(CNT_W)) u_dut (
      .clk_i(clk), .reset_ni(reset_n), .start_i(start), .step_mode_i(step_mode),
      .step_btn_i(step_btn), .pattern_i(pattern), .z_a_i(z_a), .z_b_i(z_b),
      .fsm_w_o(fsm_w), .fsm_step_o(fsm_step), .fsm_clr_o(fsm_clr), .busy_o(busy),
      .done_o(done), .mismatch_o(mismatch), .mismatch_cnt_o(mismatch_cnt), .bit_idx_o(bit_idx)
   );

   fsm_lockstep_sequencer #(.PAT_LEN(PAT_LEN), .STEP_DIV(STEP_DIV), .CNT_W(CNT2_W)) u_dut_sat (
      .clk_i(clk), .reset_ni(reset_n), .start_i(start), .step_mode_i(step_mode),
      .step_btn_i(step_btn), .pattern_i(pattern), .z_a_i(z_a), .z_b_i(z_b),
      .fsm_w_o(w2), .fsm_step_o(step2), .fsm_clr_o(clr2), .busy_o(busy2),
      .done_o(done2), .mismatch_o(mism2), .mismatch_cnt_o(cnt2), .bit_idx_o(idx2)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             w;
      logic [IDX_W-1:0] idx;
   } step_exp_t;

   typedef struct packed {
      logic              mism;
      logic [CNT_W-1:0]  cnt;
      logic [CNT2_W-1:0] cnt2;
   } done_exp_t;

   step_exp_t exp_step_q[$];
   done_exp_t exp_done_q[$];

   int total = 0;
   int bad = 0;
   int cycle = 0;
   int step_seen = 0;
   int last_step_cyc = 0;
   int z_idx = 0;
   logic [PAT_LEN-1:0] err_mask = '0;
   bit auto_run = 1'b0;
   logic clr_prev = 1'b0;
   logic done_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cycle <= cycle + 1;

   // Stand-in for the two detector FSMs: after each step, z_b disagrees with z_a where the mask says so.
   always @(negedge clk) begin
      if (fsm_step) begin
         z_a = 1'($urandom);
         z_b = (z_idx < PAT_LEN && err_mask[z_idx]) ? ~z_a : z_a;
         z_idx = z_idx + 1;
      end
   end

   always @(negedge clk) begin
      step_exp_t e;
      done_exp_t d;
      if (fsm_step) begin
         step_seen = step_seen + 1;
         check("step_expected", exp_step_q.size() != 0, 1);
         if (exp_step_q.size() != 0) begin
            e = exp_step_q.pop_front();
            check("step_w", fsm_w, e.w);
            check("step_idx", bit_idx, e.idx);
            check("step_not_clr", fsm_clr, 0);
            check("step_busy", busy, 1);
            if (auto_run && e.idx != 0) check("step_period", cycle - last_step_cyc, STEP_DIV + 2);
         end
         last_step_cyc = cycle;
      end
      if (fsm_clr) begin
         check("clr_single", clr_prev, 0);
         check("clr_w_low", fsm_w, 0);
         check("clr_busy", busy, 1);
      end
      if (done && !done_prev) begin
         check("done_expected", exp_done_q.size() != 0, 1);
         if (exp_done_q.size() != 0) begin
            d = exp_done_q.pop_front();
            check("done_mismatch", mismatch, d.mism);
            check("done_cnt", mismatch_cnt, d.cnt);
            check("done_cnt_sat", cnt2, d.cnt2);
            check("done_busy_low", busy, 0);
            check("done_w_low", fsm_w, 0);
            check("done_idx", bit_idx, PAT_LEN - 1);
         end
      end
      clr_prev = fsm_clr;
      done_prev = done;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_steps(input int target, input string name);
      int n = 0;
      while (step_seen < target && n < 1000) begin
         tick();
         n++;
      end
      check(name, step_seen >= target, 1);
   endtask

   task automatic run(input logic [PAT_LEN-1:0] pat, input logic [PAT_LEN-1:0] mask,
                      input bit manual, input int poke_at, input int abort_at);
      step_exp_t e;
      done_exp_t d;
      int pc;
      int base;
      int base2;
      int e0_cyc;
      int hold;
      pc = $countones(mask);
      for (int k = 0; k < PAT_LEN; k++) begin
         e.w = pat[k];
         e.idx = IDX_W'(k);
         exp_step_q.push_back(e);
      end
      d.mism = (mask != 0);
      d.cnt  = CNT_W'((pc > 15) ? 15 : pc);
      d.cnt2 = CNT2_W'((pc > 3) ? 3 : pc);
      exp_done_q.push_back(d);

      err_mask = mask;
      z_idx = 0;
      pattern = pat;
      step_mode = manual;
      auto_run = !manual;
      step_btn = 1'b0;
      start = 1'b0;
      tick(2);
      start = 1'b1;
      base = step_seen;
      tick();
      e0_cyc = cycle;
      pattern = ~pat;
      step_mode = ~manual;

      if (manual) begin
         tick(100);
         check("manual_idle_no_step", step_seen - base, 0);
         for (int p = 0; p < PAT_LEN; p++) begin
            hold = (p == 0) ? 10 : int'($urandom_range(1, 4));
            step_btn = 1'b1;
            tick(hold);
            step_btn = 1'b0;
            tick(3);
            check("one_step_per_press", step_seen - base, p + 1);
         end
      end else begin
         if (poke_at > 0) begin
            wait_steps(base + poke_at, "poke_reached");
            start = 1'b0;
            tick();
            start = 1'b1;
            tick();
         end
         if (abort_at > 0) begin
            wait_steps(base + abort_at, "abort_reached");
            reset_n = 1'b0;
            #1;
            check("abort_outputs_zero",
                  {fsm_w, fsm_step, fsm_clr, busy, done, mismatch, mismatch_cnt, bit_idx}, 0);
            exp_step_q.delete();
            exp_done_q.delete();
            tick(2);
            reset_n = 1'b1;
            base2 = step_seen;
            tick(30);
            check("no_step_after_reset", step_seen - base2, 0);
            check("idle_after_reset", {busy, done}, 0);
            return;
         end
      end

      while (!done && (cycle - e0_cyc) < 3000) tick();
      check("done_reached", done, 1);
      if (!manual) check("run_length", cycle - e0_cyc, RUN_EDGES);
      tick(3);
      check("done_held", {done, busy}, 2'b10);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      start = 1'b1;
      step_btn = 1'b1;
      pattern = '1;
      tick(3);
      check("reset_outputs",
            {fsm_w, fsm_step, fsm_clr, busy, done, mismatch, mismatch_cnt, bit_idx}, 0);
      check("reset_outputs_sat", {w2, step2, clr2, busy2, done2, mism2, cnt2, idx2}, 0);
      reset_n = 1'b1;
      tick(10);
      check("no_run_with_start_held", {busy, done, fsm_clr}, 0);

      run(8'b1011_0110, 8'h00, 1'b0, 0, 0);
      run(8'b1011_0110, 8'b1010_0100, 1'b0, 0, 0);
      run(PAT_LEN'($urandom), 8'hFF, 1'b0, 0, 0);
      run(PAT_LEN'($urandom), PAT_LEN'($urandom), 1'b1, 0, 0);
      run(PAT_LEN'($urandom), PAT_LEN'($urandom), 1'b0, 3, 0);
      run(PAT_LEN'($urandom), PAT_LEN'($urandom), 1'b0, 0, 4);
      run(PAT_LEN'($urandom), 8'h0F, 1'b0, 0, 0);
      run(PAT_LEN'($urandom), 8'h00, 1'b0, 0, 0);
      for (int r = 0; r < 4; r++) run(PAT_LEN'($urandom), PAT_LEN'($urandom), 1'b0, 0, 0);

      check("step_queue_drained", exp_step_q.size(), 0);
      check("done_queue_drained", exp_done_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fsm_lockstep_sequencer.md
Name: fsm_lockstep_sequencer

Overview:
- Controller that drives the one-hot and binary sequence-detector FSMs in lockstep from a programmed input pattern.
- Clears both FSMs, then presents one pattern bit per step as their shared w input and issues a one-cycle step enable.
- After each step, compares the two FSM outputs and accumulates mismatches.
- Sits between the board switches/buttons and the two FSM instances; runs either free-running (timed) or button-stepped.

Parameters:
PAT_LEN, 8, number of pattern bits applied per run (>=2)
STEP_DIV, 4, auto-mode wait in DRIVE, in clk cycles, before each step (>=1)
CNT_W, 4, width of mismatch counter

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  run request; rising edge detected internally
step_mode  input  1  0 = auto (timed steps), 1 = manual (step_btn); latched at run start
step_btn  input  1  manual step request; rising edge detected internally
pattern  input  PAT_LEN  w sequence, applied LSB first; latched at run start
z_a  input  1  output of one-hot FSM
z_b  input  1  output of binary FSM
fsm_w  output  1  w input to both FSMs
fsm_step  output  1  one-cycle step enable to both FSMs
fsm_clr  output  1  one-cycle synchronous clear to both FSMs
busy  output  1  high from CLEAR through last SAMPLE
done  output  1  high in DONE
mismatch  output  1  sticky: any compare failed this run
mismatch_cnt  output  CNT_W  number of failed compares, saturating
bit_idx  output  clog2(PAT_LEN)  index of bit currently applied

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; edge-detect history regs 0; shift reg, wait counter, latched mode cleared.
- All outputs registered. start/step_btn edge = current high and previous-cycle low.
- IDLE: outputs 0. start edge -> CLEAR; same edge latches pattern into shift reg and step_mode into mode reg; clears bit_idx, mismatch_cnt, mismatch, wait counter.
- CLEAR: fsm_clr=1, busy=1 for exactly one cycle -> DRIVE.
- DRIVE: fsm_w = shift reg LSB (valid from first DRIVE cycle).
  - Auto: wait counter counts STEP_DIV cycles, then -> STEP.
  - Manual: stay until step_btn edge -> STEP; held step_btn yields exactly one step.
- STEP: fsm_step=1 for one cycle; fsm_w held -> SAMPLE.
- SAMPLE (one cycle after step, FSM outputs settled): if z_a != z_b, mismatch<=1 and mismatch_cnt increments, saturating at 2^CNT_W-1.
  - If bit_idx==PAT_LEN-1 -> DONE.
  - Else bit_idx+1, shift reg >>1, wait counter cleared -> DRIVE.
- DONE: done=1, busy=0, fsm_w=0; mismatch, mismatch_cnt, bit_idx hold. start edge -> CLEAR (new run, new latch).
- Auto-mode step period = STEP_DIV+2 cycles; run length from start edge to done = 1 + 1 + PAT_LEN*(STEP_DIV+2) cycles.
- start edges while busy: ignored. step_btn edges in auto mode, IDLE, or DONE: ignored. step_mode/pattern changes mid-run: ignored.
- fsm_w is 0 in IDLE, CLEAR, DONE. fsm_step and fsm_clr never both high.
- Reset asserted mid-run: immediate return to IDLE, all outputs 0, no further steps.

Test Plan:
1. Reset with start=1, step_btn=1 held -> all outputs 0; after release, no run until start goes 0 then 1.
2. Auto, pattern=8'b1011_0110, z_b=z_a -> one fsm_clr pulse, then 8 fsm_step pulses every 6 cycles. fsm_w at each step: 0,1,1,0,1,1,0,1. done after 50 cycles; mismatch=0, cnt=0.
3. Same run, bench forces z_b=~z_a at steps 2, 5, 7 -> mismatch=1, mismatch_cnt=3, done=1, busy=0.
4. Manual: no fsm_step while step_btn low for 100 cycles; step_btn held high 10 cycles -> exactly one fsm_step; 8 presses -> done.
5. CNT_W=2, z_b always ~z_a -> mismatch_cnt saturates at 3, no wrap.
6. start edge at step 3 -> ignored, run completes normally; reset pulsed low at step 4 -> IDLE next, fsm_step stays 0; start edge from DONE -> new run with fresh pattern, counters cleared.
